// File: rtl/noc_link_arbiter.sv
// Wormhole output-link arbiter: round-robin grant on header flits, link held by the
// owner until its tail is accepted, single registered output stage toward the link.
//   state  | meaning
//   IDLE   | no packet owns the link; headers arbitrated round-robin
//   LOCKED | owner_q streams body/tail flits until its tail is accepted

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_link_arbiter #(
  parameter int DATA_WIDTH = `Noc_Data_Width,
  parameter int NUM_IN     = 4
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst_n,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_flit,
  input  logic [NUM_IN-1:0]            in_is_header,
  input  logic [NUM_IN-1:0]            in_is_tail,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_flit,
  input  logic                         out_VCready,
  output logic                         out_is_header,
  output logic                         out_is_tail,
  output logic [NUM_IN-1:0]            grant,
  output logic                         protocol_err
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [NUM_IN-1:0] ONE = {{(NUM_IN-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rr_last_q, rr_last_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_flit_q, out_flit_d;
  logic                  out_hdr_q, out_hdr_d;
  logic                  out_tail_q, out_tail_d;

  logic                  load_en;
  logic [NUM_IN-1:0]     cand;
  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         sel_idx;
  logic                  accept;

  assign load_en = !out_valid_q || out_ready;
  assign cand    = in_valid & in_is_header;

  // Round-robin search starting just after the last packet's owner.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = int'(rr_last_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!pick_found && cand[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    err_d     = err_q;
    in_ready  = '0;
    sel_idx   = owner_q;
    unique case (state_q)
      IDLE: begin
        sel_idx = pick_idx;
        if (pick_found && out_VCready && load_en) begin
          in_ready = ONE << pick_idx;
          if (in_is_tail[pick_idx]) begin
            rr_last_d = pick_idx;
          end else begin
            state_d = LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      LOCKED: begin
        in_ready[owner_q] = load_en;
        if (in_valid[owner_q] && load_en) begin
          if (in_is_header[owner_q]) err_d = 1'b1;
          if (in_is_tail[owner_q]) begin
            state_d   = IDLE;
            rr_last_d = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = |(in_valid & in_ready);

  // Output stage: markers and flit hold when nothing new is loaded; only valid drops.
  always_comb begin
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    out_hdr_d   = out_hdr_q;
    out_tail_d  = out_tail_q;
    if (load_en) begin
      out_valid_d = accept;
      if (accept) begin
        out_flit_d = in_flit[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        out_hdr_d  = in_is_header[sel_idx];
        out_tail_d = in_is_tail[sel_idx];
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_last_q   <= IW'(NUM_IN - 1);
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_hdr_q   <= 1'b0;
      out_tail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_hdr_q   <= out_hdr_d;
      out_tail_q  <= out_tail_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_flit      = out_flit_q;
  assign out_is_header = out_hdr_q;
  assign out_is_tail   = out_tail_q;
  assign grant         = (state_q == LOCKED) ? (ONE << owner_q) : '0;
  assign protocol_err  = err_q;

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Directed bench for noc_link_arbiter: hand-computed expected flits, grants and ready
// vectors for single packets, round-robin, backpressure, VC gating, errors and reset.

module tb_noc_link_arbiter;
  localparam int DW = 16;
  localparam int N  = 4;

  logic            noc_clk = 1'b0;
  logic            noc_rst_n;
  logic [N-1:0]    in_valid, in_ready, in_is_header, in_is_tail, grant;
  logic [N*DW-1:0] in_flit;
  logic            out_valid, out_ready, out_VCready, out_is_header, out_is_tail;
  logic            protocol_err;
  logic [DW-1:0]   out_flit;

  int n_tests = 0;
  int n_fail  = 0;
  int pkt[N];
  int ph[N];
  int cnt[N];

  always #5 noc_clk = ~noc_clk;

  noc_link_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N)) dut (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flit      (in_flit),
    .in_is_header (in_is_header),
    .in_is_tail   (in_is_tail),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_flit     (out_flit),
    .out_VCready  (out_VCready),
    .out_is_header(out_is_header),
    .out_is_tail  (out_is_tail),
    .grant        (grant),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [DW-1:0] f,
                       input logic h, input logic t);
    in_valid[i]         = v;
    in_flit[i*DW +: DW] = f;
    in_is_header[i]     = h;
    in_is_tail[i]       = t;
  endtask

  task automatic clr();
    in_valid     = '0;
    in_flit      = '0;
    in_is_header = '0;
    in_is_tail   = '0;
  endtask

  task automatic step();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    clr();
    step();
    step();
    noc_rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] enc(input int i, input int p, input int s);
    return DW'((i << 8) | (p << 4) | s);
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    noc_rst_n   = 1'b0;
    out_ready   = 1'b1;
    out_VCready = 1'b1;
    clr();
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_err", 32'(protocol_err), 32'd0);
    check("rst_flit", 32'(out_flit), 32'd0);
    step();
    noc_rst_n = 1'b1;

    // Single requester, 3-flit packet on input 0
    drive(0, 1, 16'h00A1, 1, 0);
    #1 check("sp_rdy_h", 32'(in_ready), 32'b0001);
    step();
    check("sp_flit_h", 32'(out_flit), 32'h00A1);
    check("sp_hdr", 32'(out_is_header), 32'd1);
    check("sp_grant_b", 32'(grant), 32'b0001);
    drive(0, 1, 16'h00A2, 0, 0);
    #1 check("sp_rdy_b", 32'(in_ready), 32'b0001);
    step();
    check("sp_flit_b", 32'(out_flit), 32'h00A2);
    check("sp_grant_b2", 32'(grant), 32'b0001);
    drive(0, 1, 16'h00A3, 0, 1);
    step();
    check("sp_flit_t", 32'(out_flit), 32'h00A3);
    check("sp_tail", 32'(out_is_tail), 32'd1);
    check("sp_grant_end", 32'(grant), 32'd0);
    clr();
    step();
    check("sp_valid_drop", 32'(out_valid), 32'd0);
    check("sp_err", 32'(protocol_err), 32'd0);

    // Round-robin: all inputs hold 2-flit packets continuously
    do_reset();
    for (int i = 0; i < N; i++) begin pkt[i] = 0; ph[i] = 0; end
    for (int c = 0; c < 10; c++) begin
      int ex;
      ex = (c / 2) % N;
      for (int i = 0; i < N; i++)
        drive(i, 1, enc(i, pkt[i], ph[i]), ph[i] == 0, ph[i] == 1);
      #1 check("rr_rdy", 32'(in_ready), 32'(1 << ex));
      for (int i = 0; i < N; i++)
        if (in_ready[i]) begin
          if (ph[i] == 1) begin ph[i] = 0; pkt[i]++; end
          else ph[i] = 1;
        end
      step();
      check("rr_flit", 32'(out_flit), 32'(enc(ex, c / 8, c % 2)));
      check("rr_valid", 32'(out_valid), 32'd1);
    end
    clr();
    step();

    // Backpressure mid-packet on input 1 (input 0 was last owner)
    drive(1, 1, 16'h0010, 1, 0);
    #1 check("bp_rdy_h", 32'(in_ready), 32'b0010);
    step();
    drive(1, 1, 16'h0011, 0, 0);
    step();
    check("bp_flit_b1", 32'(out_flit), 32'h0011);
    out_ready = 1'b0;
    drive(1, 1, 16'h0012, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1 check("bp_rdy_hold", 32'(in_ready), 32'd0);
      step();
      check("bp_flit_hold", 32'(out_flit), 32'h0011);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_rdy_resume", 32'(in_ready), 32'b0010);
    step();
    check("bp_flit_b2", 32'(out_flit), 32'h0012);
    drive(1, 1, 16'h0013, 0, 1);
    step();
    check("bp_flit_t", 32'(out_flit), 32'h0013);
    check("bp_grant_end", 32'(grant), 32'd0);
    clr();
    step();

    // VC gating with headers pending on inputs 1 and 2
    do_reset();
    out_VCready = 1'b0;
    drive(1, 1, 16'h0031, 1, 0);
    drive(2, 1, 16'h0041, 1, 0);
    for (int c = 0; c < 2; c++) begin
      #1 check("vc_rdy_blk", 32'(in_ready), 32'd0);
      step();
      check("vc_valid_blk", 32'(out_valid), 32'd0);
      check("vc_grant_blk", 32'(grant), 32'd0);
    end
    out_VCready = 1'b1;
    #1 check("vc_rdy_go", 32'(in_ready), 32'b0010);
    step();
    check("vc_flit_h", 32'(out_flit), 32'h0031);
    check("vc_grant", 32'(grant), 32'b0010);
    out_VCready = 1'b0;
    drive(1, 1, 16'h0032, 0, 0);
    #1 check("vc_rdy_locked", 32'(in_ready), 32'b0010);
    step();
    check("vc_flit_b", 32'(out_flit), 32'h0032);
    drive(1, 1, 16'h0033, 0, 1);
    step();
    check("vc_flit_t", 32'(out_flit), 32'h0033);
    check("vc_grant_end", 32'(grant), 32'd0);
    drive(1, 0, 16'h0000, 0, 0);
    #1 check("vc_rdy_in2_blk", 32'(in_ready), 32'd0);
    step();
    check("vc_valid_after", 32'(out_valid), 32'd0);
    out_VCready = 1'b1;
    clr();

    // Single-flit packets from inputs 2 and 3 (last owner was 1)
    cnt[2] = 0;
    cnt[3] = 0;
    for (int c = 0; c < 4; c++) begin
      int ex;
      ex = 2 + (c % 2);
      drive(2, 1, enc(2, cnt[2], 0), 1, 1);
      drive(3, 1, enc(3, cnt[3], 0), 1, 1);
      #1 check("sf_rdy", 32'(in_ready), 32'(1 << ex));
      if (in_ready[2]) cnt[2]++;
      if (in_ready[3]) cnt[3]++;
      step();
      check("sf_flit", 32'(out_flit), 32'(enc(ex, c / 2, 0)));
      check("sf_ht", 32'({out_is_header, out_is_tail}), 32'b11);
      check("sf_grant", 32'(grant), 32'd0);
    end
    clr();

    // Protocol error: second header from owner (last owner 3, so input 0 next)
    drive(0, 1, 16'h0051, 1, 0);
    #1 check("er_rdy", 32'(in_ready), 32'b0001);
    step();
    check("er_err0", 32'(protocol_err), 32'd0);
    drive(0, 1, 16'h0052, 1, 0);
    step();
    check("er_err1", 32'(protocol_err), 32'd1);
    check("er_fwd", 32'(out_flit), 32'h0052);
    drive(0, 1, 16'h0053, 0, 0);
    step();
    check("er_sticky", 32'(protocol_err), 32'd1);
    check("er_grant", 32'(grant), 32'b0001);

    // Reset mid-packet takes effect immediately
    noc_rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_grant", 32'(grant), 32'd0);
    check("mr_err", 32'(protocol_err), 32'd0);
    step();
    noc_rst_n = 1'b1;
    for (int i = 0; i < N; i++) drive(i, 1, enc(i, 7, 0), 1, 1);
    #1 check("mr_prio", 32'(in_ready), 32'b0001);
    step();
    check("mr_flit", 32'(out_flit), 32'(enc(0, 7, 0)));
    clr();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
